// File: rtl/telem_rx.sv
// eBike telemetry receiver: 8N1 UART plus AA 55 framed battery/current/torque parser.
// Define TELEM_CHKSUM_EN to require a trailing modulo-256 payload checksum byte.
module telem_rx #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] torque,
    output logic        vld,
    output logic        frm_err
);

    localparam logic [15:0] FULL_LD = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LD = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ust_t;
    typedef enum logic [1:0] {P_HDR1, P_HDR2, P_PAYLOAD, P_CHK} pst_t;

    ust_t        ust_q, ust_d;
    pst_t        pst_q, pst_d;
    logic        rx_meta_q, rx_sync_q;
    logic        armed_q, armed_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bitn_q, bitn_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        rdy_q, rdy_d;
    logic        stop_bad;
    logic [2:0]  idx_q, idx_d;
    logic [35:0] shadow_q, shadow_d;
    logic [11:0] batt_q, batt_d, curr_q, curr_d, torque_q, torque_d;
    logic        vld_q, vld_d, err_q, err_d;
    logic        commit;
`ifdef TELEM_CHKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    // Start detection is level-based once the line has been seen high, so a
    // held-low break keeps re-triggering and reports repeated framing errors.
    always_comb begin
        ust_d    = ust_q;
        cnt_d    = cnt_q;
        bitn_d   = bitn_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        rdy_d    = 1'b0;
        stop_bad = 1'b0;
        armed_d  = armed_q | rx_sync_q;
        case (ust_q)
            U_IDLE: begin
                if (armed_q && !rx_sync_q) begin
                    ust_d = U_START;
                    cnt_d = HALF_LD;
                end
            end
            U_START: begin
                if (cnt_q == 16'd0) begin
                    if (!rx_sync_q) begin
                        ust_d  = U_DATA;
                        cnt_d  = FULL_LD;
                        bitn_d = 3'd0;
                    end else begin
                        ust_d = U_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            U_DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = FULL_LD;
                    bitn_d  = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) ust_d = U_STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                if (cnt_q == 16'd0) begin
                    ust_d = U_IDLE;
                    if (rx_sync_q) begin
                        rdy_d  = 1'b1;
                        byte_d = shift_q;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
        endcase
    end

    always_comb begin
        pst_d    = pst_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        vld_d    = 1'b0;
        err_d    = stop_bad;
        commit   = 1'b0;
`ifdef TELEM_CHKSUM_EN
        sum_d    = sum_q;
`endif
        if (stop_bad) begin
            pst_d = P_HDR1;
        end else if (rdy_q) begin
            case (pst_q)
                P_HDR1: if (byte_q == 8'hAA) pst_d = P_HDR2;
                P_HDR2: begin
                    if (byte_q == 8'h55) begin
                        pst_d = P_PAYLOAD;
                        idx_d = 3'd0;
`ifdef TELEM_CHKSUM_EN
                        sum_d = 8'd0;
`endif
                    end else if (byte_q != 8'hAA) begin
                        pst_d = P_HDR1;
                    end
                end
                P_PAYLOAD: begin
                    if (!idx_q[0] && byte_q[7:4] != 4'h0) begin
                        err_d = 1'b1;
                        pst_d = P_HDR1;
                    end else begin
                        // High bytes contribute only their nibble to the field.
                        shadow_d = idx_q[0] ? {shadow_q[27:0], byte_q}
                                            : {shadow_q[31:0], byte_q[3:0]};
                        idx_d = idx_q + 3'd1;
`ifdef TELEM_CHKSUM_EN
                        sum_d = sum_q + byte_q;
                        if (idx_q == 3'd5) pst_d = P_CHK;
`else
                        if (idx_q == 3'd5) begin
                            commit = 1'b1;
                            pst_d  = P_HDR1;
                        end
`endif
                    end
                end
                default: begin
`ifdef TELEM_CHKSUM_EN
                    if (byte_q == sum_q) commit = 1'b1;
                    else err_d = 1'b1;
`endif
                    pst_d = P_HDR1;
                end
            endcase
        end
        vld_d    = commit;
        batt_d   = commit ? shadow_d[35:24] : batt_q;
        curr_d   = commit ? shadow_d[23:12] : curr_q;
        torque_d = commit ? shadow_d[11:0]  : torque_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
            armed_q   <= 1'b0;
            ust_q     <= U_IDLE;
            cnt_q     <= 16'd0;
            bitn_q    <= 3'd0;
            shift_q   <= 8'd0;
            byte_q    <= 8'd0;
            rdy_q     <= 1'b0;
            pst_q     <= P_HDR1;
            idx_q     <= 3'd0;
            shadow_q  <= 36'd0;
            batt_q    <= 12'd0;
            curr_q    <= 12'd0;
            torque_q  <= 12'd0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
`ifdef TELEM_CHKSUM_EN
            sum_q     <= 8'd0;
`endif
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            armed_q   <= armed_d;
            ust_q     <= ust_d;
            cnt_q     <= cnt_d;
            bitn_q    <= bitn_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            rdy_q     <= rdy_d;
            pst_q     <= pst_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            batt_q    <= batt_d;
            curr_q    <= curr_d;
            torque_q  <= torque_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
`ifdef TELEM_CHKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign batt    = batt_q;
    assign curr    = curr_q;
    assign torque  = torque_q;
    assign vld     = vld_q;
    assign frm_err = err_q;

endmodule

// File: tb/tb_telem_rx.sv
// Scoreboard bench for telem_rx at BAUD_DIV=16 with directed frames.
// Exercises the TELEM_CHKSUM_EN checksum cases when that macro is defined.
module tb_telem_rx;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX  = 1'b1;
    logic [11:0] batt, curr, torque;
    logic        vld, frm_err;

    telem_rx #(.BAUD_DIV(BD)) dut (
        .clk(clk), .rst(rst), .RX(RX),
        .batt(batt), .curr(curr), .torque(torque),
        .vld(vld), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    logic [35:0] exp_q[$];
    logic [35:0] last;
    int n_vec = 0, n_err = 0;
    int mon_vec = 0, mon_err = 0;
    int err_seen = 0, exp_errs = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (frm_err) err_seen++;
            if (vld && frm_err) begin
                mon_vec++;
                mon_err++;
                $display("FAIL excl: vld=%0b frm_err=%0b, required not both", vld, frm_err);
            end
            if (vld) begin
                mon_vec++;
                if (exp_q.size() == 0) begin
                    mon_err++;
                    $display("FAIL unexpected_vld: got %h/%h/%h, required no vld", batt, curr, torque);
                end else begin
                    logic [35:0] e;
                    e = exp_q.pop_front();
                    if ({batt, curr, torque} !== e) begin
                        mon_err++;
                        $display("FAIL frame: got %h, required %h", {batt, curr, torque}, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * BD) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        RX = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            wait_bits(1);
        end
        RX = stop_ok;
        wait_bits(1);
        if (!stop_ok) begin
            RX = 1'b1;
            wait_bits(2);
        end
    endtask

    // bad_idx: byte position (0 = first 0xAA) whose stop bit is driven low.
    task automatic send_frame(input logic [11:0] b, input logic [11:0] c,
                              input logic [11:0] t, input int bad_idx,
                              input logic [7:0] csum_xor);
        logic [7:0] by[8];
        logic [7:0] s;
        by[0] = 8'hAA; by[1] = 8'h55;
        by[2] = {4'h0, b[11:8]}; by[3] = b[7:0];
        by[4] = {4'h0, c[11:8]}; by[5] = c[7:0];
        by[6] = {4'h0, t[11:8]}; by[7] = t[7:0];
        s = 8'h00;
        for (int i = 2; i < 8; i++) s = s + by[i];
        for (int i = 0; i < 8; i++) send_byte(by[i], i != bad_idx);
`ifdef TELEM_CHKSUM_EN
        send_byte(s ^ csum_xor);
`endif
    endtask

    task automatic settle(input string nm);
        wait_bits(3);
        chk({nm, "_errs"}, 36'(err_seen), 36'(exp_errs));
        chk({nm, "_pending"}, 36'(exp_q.size()), 36'd0);
        chk({nm, "_hold"}, {batt, curr, torque}, last);
    endtask

    initial begin
        last = 36'd0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_out", {batt, curr, torque}, 36'd0);
        chk("reset_flags", {34'd0, vld, frm_err}, 36'd0);
        rst = 1'b0;
        wait_bits(2);

        // nominal
        last = {12'hB11, 12'h123, 12'h600};
        exp_q.push_back(last);
        send_frame(12'hB11, 12'h123, 12'h600, -1, 8'h00);
        settle("nominal");

        // header resync: AA AA 55 then zero payload
        last = 36'd0;
        exp_q.push_back(last);
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_byte(8'h55);
        for (int i = 0; i < 6; i++) send_byte(8'h00);
`ifdef TELEM_CHKSUM_EN
        send_byte(8'h00);
`endif
        settle("resync");
        send_byte(8'hAA);
        send_byte(8'h12);
        settle("hdr_drop");

        // bad stop bit on byte 4, framed by good frames
        last = {12'h5A3, 12'h0FF, 12'h800};
        exp_q.push_back(last);
        send_frame(12'h5A3, 12'h0FF, 12'h800, -1, 8'h00);
        exp_errs++;
        send_frame(12'hB11, 12'h123, 12'h600, 3, 8'h00);
        settle("bad_stop");
        last = {12'h0C4, 12'hF00, 12'h00A};
        exp_q.push_back(last);
        send_frame(12'h0C4, 12'hF00, 12'h00A, -1, 8'h00);
        settle("after_stop");

        // format error: batt high byte 0x1B
        exp_errs++;
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h1B);
        send_byte(8'h11);
        send_byte(8'h01);
        send_byte(8'h23);
        send_byte(8'h06);
        send_byte(8'h00);
`ifdef TELEM_CHKSUM_EN
        send_byte(8'h46);
`endif
        settle("format");

`ifdef TELEM_CHKSUM_EN
        last = {12'hB11, 12'h123, 12'h600};
        exp_q.push_back(last);
        send_byte(8'hAA); send_byte(8'h55);
        send_byte(8'h0B); send_byte(8'h11); send_byte(8'h01);
        send_byte(8'h23); send_byte(8'h06); send_byte(8'h00);
        send_byte(8'h46);
        settle("csum_ok");
        exp_errs++;
        send_byte(8'hAA); send_byte(8'h55);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
        send_byte(8'h16);
        send_byte(8'hAA); send_byte(8'h55);
        send_byte(8'h0B); send_byte(8'h11); send_byte(8'h01);
        send_byte(8'h23); send_byte(8'h06); send_byte(8'h00);
        send_byte(8'h47);
        exp_errs++;
        settle("csum_bad");
`endif

        // reset in the middle of byte 5
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h0B);
        send_byte(8'h11);
        RX = 1'b0;
        wait_bits(1);
        RX = 1'b1;
        wait_bits(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_out", {batt, curr, torque}, 36'd0);
        rst = 1'b0;
        last = 36'd0;
        wait_bits(12);
        last = {12'h321, 12'h0AB, 12'hFFF};
        exp_q.push_back(last);
        send_frame(12'h321, 12'h0AB, 12'hFFF, -1, 8'h00);
        settle("post_reset");

        n_vec += mon_vec;
        n_err += mon_err;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
